// File: rtl/unidade_busca.sv
// -----------------------------------------------------------------------------
// unidade_busca -- MIPS32 instruction-fetch stage
//
// Holds the program counter and drives it to an asynchronous-read instruction
// memory. The word returned in the same cycle is captured into the IF/ID
// pipeline register. Jump/branch redirects, stalls from the hazard unit and a
// sticky misaligned-target fault are handled here. A counter of instructions
// accepted into IF/ID is kept for UART reporting.
//
// Ports:
//   clock            rising-edge clock
//   reset_n          synchronous reset, active-low
//   stall            hazard-unit hold: freezes pc and IF/ID
//   salto_valido     jump taken this cycle (has priority over desvio)
//   salto_alvo       jump target
//   desvio_valido    branch taken this cycle
//   desvio_alvo      branch target
//   pc               current PC, address to instruction memory
//   instrucao        word returned by memory for pc (combinational)
//   if_id_instrucao  registered instruction for decode
//   if_id_pc4        registered PC+4 of that instruction
//   if_id_valido     1 = real instruction in IF/ID, 0 = bubble
//   excecao          sticky misaligned-target fault flag
//   epc              offending target captured on fault
//   contador         number of instructions accepted into IF/ID
// -----------------------------------------------------------------------------
module unidade_busca #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        salto_valido,
  input  logic [31:0] salto_alvo,
  input  logic        desvio_valido,
  input  logic [31:0] desvio_alvo,
  output logic [31:0] pc,
  input  logic [31:0] instrucao,
  output logic [31:0] if_id_instrucao,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valido,
  output logic        excecao,
  output logic [31:0] epc,
  output logic [31:0] contador
);

  logic [31:0] pc_mais4;
  logic        redirect;
  logic [31:0] alvo;
  logic        alvo_desalinhado;

  // Wraps modulo 2^32 naturally: 32'hFFFFFFFC + 4 = 0.
  assign pc_mais4         = pc + 32'd4;
  assign redirect         = salto_valido | desvio_valido;
  // A jump beats a branch resolved in the same cycle.
  assign alvo             = salto_valido ? salto_alvo : desvio_alvo;
  assign alvo_desalinhado = |alvo[1:0];

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would let pc_mais4 see the updated pc.
  always_ff @(posedge clock) begin
    // NOTE: reset is synchronous and sits first in the priority chain, so it
    // overrides a pending stall, redirect or latched fault on the same edge.
    if (!reset_n) begin
      pc              <= PC_RESET;
      if_id_instrucao <= NOP_WORD;
      if_id_pc4       <= 32'd0;
      if_id_valido    <= 1'b0;
      excecao         <= 1'b0;
      epc             <= 32'd0;
      contador        <= 32'd0;
    end else if (excecao) begin
      // Halted: keep feeding bubbles to decode until reset.
      if_id_instrucao <= NOP_WORD;
      if_id_valido    <= 1'b0;
    end else if (redirect) begin
      // The word fetched this cycle is on the wrong path; squash it.
      if_id_instrucao <= NOP_WORD;
      if_id_valido    <= 1'b0;
      if (alvo_desalinhado) begin
        excecao <= 1'b1;
        epc     <= alvo;
      end else begin
        pc <= alvo;
      end
    end else if (!stall) begin
      pc              <= pc_mais4;
      if_id_instrucao <= instrucao;
      if_id_pc4       <= pc_mais4;
      if_id_valido    <= 1'b1;
      contador        <= contador + 32'd1;
    end
  end

endmodule
